traffic_ctrl: RTL and testbench



---
 rtl/traffic_pkg.sv | 37 +++
 rtl/traffic_ctrl_if.sv | 30 +++
 rtl/bin2bcd99.sv | 19 +
 rtl/traffic_ctrl.sv | 118 +++++++++++
 tb/tb_traffic_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_pkg                                                          |
// | Shared state encoding, default phase durations and counter width.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package traffic_pkg;

    localparam int CNT_W         = 7;
    localparam int DEF_GREEN_S   = 25;
    localparam int DEF_YELLOW_S  = 3;
    localparam int DEF_ALL_RED_S = 2;

    typedef enum logic [2:0] {
        ALL_RED1  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED2  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        FLASH     = 3'd6
    } state_t;

    // FLASH is never reached through the normal ring; it falls to ALL_RED1.
    function automatic state_t next_phase(input state_t s);
        case (s)
            ALL_RED1:  return NS_GREEN;
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return ALL_RED2;
            ALL_RED2:  return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            default:   return ALL_RED1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_ctrl_if                                                      |
// | Tick/switch inputs and lamp/display outputs of the controller.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface traffic_ctrl_if;
    logic       tick_src;
    logic       night_mode;
    logic       ns_r;
    logic       ns_y;
    logic       ns_g;
    logic       ew_r;
    logic       ew_y;
    logic       ew_g;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [2:0] phase;

    modport master (
        output tick_src, night_mode,
        input  ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, sec_tens, sec_ones, phase
    );

    modport slave (
        input  tick_src, night_mode,
        output ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, sec_tens, sec_ones, phase
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd99.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin2bcd99                                                            |
// | Combinational binary (0..99) to two-digit BCD converter.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bin2bcd99
    import traffic_pkg::*;
(
    input  logic [CNT_W-1:0] bin,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    assign tens = 4'(bin / CNT_W'(10));
    assign ones = 4'(bin % CNT_W'(10));

endmodule
`default_nettype wire

// File: rtl/traffic_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_ctrl                                                         |
// | Two-way intersection sequencer with night flashing-yellow mode.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_S   = DEF_GREEN_S,
    parameter int YELLOW_S  = DEF_YELLOW_S,
    parameter int ALL_RED_S = DEF_ALL_RED_S
) (
    input  logic          clk_in,
    input  logic          rst_n,
    traffic_ctrl_if.slave bus
);

    logic             tick_src_d;
    logic             tick;
    logic             night_m;
    logic             night_s;
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] remain;
    logic [CNT_W-1:0] remain_nx;
    logic             flash_ph;
    logic             flash_nx;
    logic [3:0]       tens;
    logic [3:0]       ones;

    function automatic logic [CNT_W-1:0] dur_of(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   return CNT_W'(GREEN_S);
            NS_YELLOW, EW_YELLOW: return CNT_W'(YELLOW_S);
            default:              return CNT_W'(ALL_RED_S);
        endcase
    endfunction

    // tick_src is already a clk_in-domain flop, so only an edge detect is needed.
    assign tick = bus.tick_src & ~tick_src_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_src_d <= 1'b0;
            night_m    <= 1'b0;
            night_s    <= 1'b0;
            state      <= ALL_RED1;
            remain     <= CNT_W'(ALL_RED_S);
            flash_ph   <= 1'b0;
        end else begin
            tick_src_d <= bus.tick_src;
            night_m    <= bus.night_mode;
            night_s    <= night_m;
            state      <= state_nx;
            remain     <= remain_nx;
            flash_ph   <= flash_nx;
        end
    end

    // Night-mode transitions take precedence over a coincident tick.
    always_comb begin
        state_nx  = state;
        remain_nx = remain;
        flash_nx  = flash_ph;
        if (state != FLASH) begin
            if (night_s) begin
                state_nx  = FLASH;
                remain_nx = '0;
                flash_nx  = 1'b1;
            end else if (tick) begin
                if (remain <= CNT_W'(1)) begin
                    state_nx  = next_phase(state);
                    remain_nx = dur_of(next_phase(state));
                end else begin
                    remain_nx = remain - CNT_W'(1);
                end
            end
        end else begin
            if (!night_s) begin
                state_nx  = ALL_RED1;
                remain_nx = CNT_W'(ALL_RED_S);
                flash_nx  = 1'b0;
            end else if (tick) begin
                flash_nx = ~flash_ph;
            end
        end
    end

    always_comb begin
        bus.ns_r = 1'b0;
        bus.ns_y = 1'b0;
        bus.ns_g = 1'b0;
        bus.ew_r = 1'b0;
        bus.ew_y = 1'b0;
        bus.ew_g = 1'b0;
        case (state)
            NS_GREEN:  begin bus.ns_g = 1'b1; bus.ew_r = 1'b1; end
            NS_YELLOW: begin bus.ns_y = 1'b1; bus.ew_r = 1'b1; end
            EW_GREEN:  begin bus.ns_r = 1'b1; bus.ew_g = 1'b1; end
            EW_YELLOW: begin bus.ns_r = 1'b1; bus.ew_y = 1'b1; end
            FLASH:     begin bus.ns_y = flash_ph; bus.ew_y = flash_ph; end
            default:   begin bus.ns_r = 1'b1; bus.ew_r = 1'b1; end
        endcase
    end

    bin2bcd99 u_bcd (
        .bin  (remain),
        .tens (tens),
        .ones (ones)
    );

    assign bus.sec_tens = tens;
    assign bus.sec_ones = ones;
    assign bus.phase    = state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_traffic_ctrl                                                      |
// | Directed bench: GREEN 5 / YELLOW 2 / ALL_RED 1, plus a GREEN 12 copy.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_traffic_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic tick_src;
    logic night_mode;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    traffic_ctrl_if bus ();
    traffic_ctrl_if bus12 ();

    assign bus.tick_src     = tick_src;
    assign bus.night_mode   = night_mode;
    assign bus12.tick_src   = tick_src;
    assign bus12.night_mode = 1'b0;

    traffic_ctrl #(.GREEN_S(5), .YELLOW_S(2), .ALL_RED_S(1)) dut (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    traffic_ctrl #(.GREEN_S(12), .YELLOW_S(2), .ALL_RED_S(1)) dut12 (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus12)
    );

    // {phase, tens, ones, ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
    wire [16:0] obs = {bus.phase, bus.sec_tens, bus.sec_ones,
                       bus.ns_r, bus.ns_y, bus.ns_g, bus.ew_r, bus.ew_y, bus.ew_g};

    function automatic logic [16:0] exp_of(input int ph, input int rem, input bit fl);
        logic [5:0] l;
        case (ph)
            1:       l = 6'b001_100;
            2:       l = 6'b010_100;
            4:       l = 6'b100_001;
            5:       l = 6'b100_010;
            6:       l = fl ? 6'b010_010 : 6'b000_000;
            default: l = 6'b100_100;
        endcase
        return {3'(ph), 4'(rem / 10), 4'(rem % 10), l};
    endfunction

    // Called on a falling edge; one full 20-high / 20-low period.
    task automatic tick();
        tick_src = 1'b1;
        repeat (20) @(negedge clk);
        tick_src = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        tick_src   = 1'b0;
        night_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        tick_src   = 1'b0;
        night_mode = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== exp_of(0, 1, 0)) begin
            failures++;
            $display("FAIL reset_held got=%h exp=%h", obs, exp_of(0, 1, 0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== exp_of(0, 1, 0)) begin
            failures++;
            $display("FAIL reset_released got=%h exp=%h", obs, exp_of(0, 1, 0));
        end
        tick();
        checks++;
        if (obs !== exp_of(1, 5, 0)) begin
            failures++;
            $display("FAIL first_tick got=%h exp=%h", obs, exp_of(1, 5, 0));
        end
    endtask

    task automatic test_cycle();
        int ph [17] = '{1, 1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 4, 5, 5, 0, 1};
        int rm [17] = '{5, 4, 3, 2, 1, 2, 1, 1, 5, 4, 3, 2, 1, 2, 1, 1, 5};
        apply_reset();
        for (int k = 0; k < 17; k++) begin
            tick();
            checks++;
            if (obs !== exp_of(ph[k], rm[k], 0)) begin
                failures++;
                $display("FAIL cycle_tick%0d got=%h exp=%h", k + 1, obs, exp_of(ph[k], rm[k], 0));
            end
        end
    endtask

    task automatic test_bcd();
        logic [7:0]  digits [13] = '{8'h12, 8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                                     8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h02};
        logic [10:0] got;
        logic [10:0] want;
        apply_reset();
        for (int k = 0; k < 13; k++) begin
            tick();
            got  = {bus12.phase, bus12.sec_tens, bus12.sec_ones};
            want = {(k < 12) ? 3'd1 : 3'd2, digits[k]};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL bcd12_tick%0d got=%h exp=%h", k + 1, got, want);
            end
        end
    endtask

    task automatic test_night();
        apply_reset();
        tick();
        tick();
        night_mode = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== exp_of(1, 4, 0)) begin
            failures++;
            $display("FAIL night_sync_delay got=%h exp=%h", obs, exp_of(1, 4, 0));
        end
        @(negedge clk);
        checks++;
        if (obs !== exp_of(6, 0, 1)) begin
            failures++;
            $display("FAIL night_enter got=%h exp=%h", obs, exp_of(6, 0, 1));
        end
        tick();
        checks++;
        if (obs !== exp_of(6, 0, 0)) begin
            failures++;
            $display("FAIL flash_toggle_off got=%h exp=%h", obs, exp_of(6, 0, 0));
        end
        tick();
        checks++;
        if (obs !== exp_of(6, 0, 1)) begin
            failures++;
            $display("FAIL flash_toggle_on got=%h exp=%h", obs, exp_of(6, 0, 1));
        end
        night_mode = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== exp_of(6, 0, 1)) begin
            failures++;
            $display("FAIL night_exit_delay got=%h exp=%h", obs, exp_of(6, 0, 1));
        end
        @(negedge clk);
        checks++;
        if (obs !== exp_of(0, 1, 0)) begin
            failures++;
            $display("FAIL night_exit got=%h exp=%h", obs, exp_of(0, 1, 0));
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (10) tick();
        checks++;
        if (obs !== exp_of(4, 4, 0)) begin
            failures++;
            $display("FAIL pre_reset_ew_green got=%h exp=%h", obs, exp_of(4, 4, 0));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== exp_of(0, 1, 0)) begin
            failures++;
            $display("FAIL async_reset_immediate got=%h exp=%h", obs, exp_of(0, 1, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== exp_of(1, 5, 0)) begin
            failures++;
            $display("FAIL resume_green got=%h exp=%h", obs, exp_of(1, 5, 0));
        end
        repeat (5) tick();
        checks++;
        if (obs !== exp_of(2, 2, 0)) begin
            failures++;
            $display("FAIL resume_yellow got=%h exp=%h", obs, exp_of(2, 2, 0));
        end
    endtask

    task automatic test_night_tick_same();
        apply_reset();
        night_mode = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (obs !== exp_of(6, 0, 1)) begin
            failures++;
            $display("FAIL same_flash got=%h exp=%h", obs, exp_of(6, 0, 1));
        end
        night_mode = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tick_src = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== exp_of(0, 1, 0)) begin
            failures++;
            $display("FAIL same_cycle_exit got=%h exp=%h", obs, exp_of(0, 1, 0));
        end
        repeat (20) @(negedge clk);
        tick_src = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (obs !== exp_of(0, 1, 0)) begin
            failures++;
            $display("FAIL same_cycle_hold got=%h exp=%h", obs, exp_of(0, 1, 0));
        end
        tick();
        checks++;
        if (obs !== exp_of(1, 5, 0)) begin
            failures++;
            $display("FAIL same_cycle_next got=%h exp=%h", obs, exp_of(1, 5, 0));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        tick_src   = 1'b0;
        night_mode = 1'b0;
        test_reset();
        test_cycle();
        test_bcd();
        test_night();
        test_async_reset();
        test_night_tick_same();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
